// File: rtl/gs_pkg.sv
// Shared encodings for the General Sound host-side initiator: ops, ports, flags, FSM states.
package gs_pkg;

  typedef enum logic [1:0] {
    GS_OP_WR_DATA = 2'b00,
    GS_OP_WR_CMD  = 2'b01,
    GS_OP_RD_DATA = 2'b10,
    GS_OP_RD_STAT = 2'b11
  } gs_op_e;

  localparam logic [7:0] GS_PORT_DATA = 8'hB3;
  localparam logic [7:0] GS_PORT_CMD  = 8'hBB;

  localparam int GS_FLAG_DATA = 7;
  localparam int GS_FLAG_CMD  = 0;

  typedef enum logic [2:0] {
    GS_IDLE,
    GS_SETUP,
    GS_STROBE,
    GS_RELEASE,
    GS_EVAL,
    GS_GAP,
    GS_DONE
  } gs_state_e;

endpackage

// File: rtl/gs_io_cycle.sv
// One SETUP / STROBE / RELEASE host I/O cycle; DI is captured on the last strobe clock.
module gs_io_cycle
  import gs_pkg::*;
#(
  parameter int STROBE = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [7:0]  addr_i,
  input  logic        rd_i,
  input  logic [7:0]  wdata_i,
  input  logic [7:0]  di_i,
  output logic [15:0] a_o,
  output logic [7:0]  do_o,
  output logic        iorq_n_o,
  output logic        rd_n_o,
  output logic        wr_n_o,
  output logic        done_o,
  output logic [7:0]  rdata_o
);

  localparam logic [3:0] STB_M1 = 4'(STROBE - 1);

  gs_state_e  state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] addr_q, addr_d;
  logic       rd_q, rd_d;
  logic [7:0] wdata_q, wdata_d;
  logic [7:0] rdata_q, rdata_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= GS_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 8'h00;
      rd_q    <= 1'b0;
      wdata_q <= 8'h00;
      rdata_q <= 8'h00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      rd_q    <= rd_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    rd_d    = rd_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    unique case (state_q)
      GS_IDLE, GS_RELEASE: begin
        // a new cycle may start straight out of RELEASE so GAP = 0 costs no extra clock
        if (start_i) begin
          state_d = GS_SETUP;
          addr_d  = addr_i;
          rd_d    = rd_i;
          wdata_d = wdata_i;
        end else begin
          state_d = GS_IDLE;
        end
      end
      GS_SETUP: begin
        state_d = GS_STROBE;
        cnt_d   = STB_M1;
      end
      GS_STROBE: begin
        if (cnt_q == 4'd0) begin
          state_d = GS_RELEASE;
          if (rd_q) rdata_d = di_i;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = GS_IDLE;
    endcase
  end

  always_comb begin
    logic active;
    active   = (state_q == GS_SETUP) || (state_q == GS_STROBE) || (state_q == GS_RELEASE);
    a_o      = active ? {8'h00, addr_q} : 16'h0000;
    do_o     = (active && !rd_q) ? wdata_q : 8'h00;
    iorq_n_o = !((state_q == GS_SETUP) || (state_q == GS_STROBE));
    rd_n_o   = !((state_q == GS_STROBE) && rd_q);
    wr_n_o   = !((state_q == GS_STROBE) && !rd_q);
    done_o   = (state_q == GS_RELEASE);
    rdata_o  = rdata_q;
  end

endmodule

// File: rtl/gs_host_master.sv
// GS mailbox host initiator: status polling, gap timing and response FSM around gs_io_cycle.
// Define GS_HOST_TIMEOUT_EN to build the failed-poll counter and abort after TIMEOUT polls.
module gs_host_master
  import gs_pkg::*;
#(
  parameter int STROBE  = 4,
  parameter int GAP     = 2,
  parameter int TIMEOUT = 65535
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        REQ_VALID,
  output logic        REQ_READY,
  input  logic [1:0]  REQ_OP,
  input  logic [7:0]  REQ_DATA,
  output logic        RSP_VALID,
  output logic [7:0]  RSP_DATA,
  output logic        RSP_TIMEOUT,
  output logic        BUSY,
  output logic [15:0] A,
  output logic [7:0]  DO,
  input  logic [7:0]  DI,
  output logic        IORQ_n,
  output logic        RD_n,
  output logic        WR_n,
  output logic        M1_n
);

  if (STROBE < 1 || STROBE > 15 || GAP < 0 || GAP > 15 || TIMEOUT < 1 || TIMEOUT > 65535) begin : g_param_check
    $error("gs_host_master: parameter out of range");
  end

  localparam logic [3:0] GAP_M1 = 4'((GAP > 0) ? GAP - 1 : 0);

  gs_state_e  state_q, state_d;
  gs_op_e     op_q, cur_op;
  logic [7:0] data_q;
  logic       xfer_q, xfer_d;
  logic [3:0] gap_q, gap_d;
  logic [7:0] stat_q, stat_d;
  logic [7:0] rsp_data_q, rsp_data_d;
  logic       accept, poll_ok;
  logic       io_start, io_rd, io_done;
  logic [7:0] io_addr, io_wdata, io_rdata;
`ifdef GS_HOST_TIMEOUT_EN
  logic        rsp_to_q, rsp_to_d;
  logic [15:0] fail_q, fail_d, fail_inc;
`endif

  gs_io_cycle #(.STROBE(STROBE)) u_io (
    .clk_i    (CLK),
    .rst_i    (RESET),
    .start_i  (io_start),
    .addr_i   (io_addr),
    .rd_i     (io_rd),
    .wdata_i  (io_wdata),
    .di_i     (DI),
    .a_o      (A),
    .do_o     (DO),
    .iorq_n_o (IORQ_n),
    .rd_n_o   (RD_n),
    .wr_n_o   (WR_n),
    .done_o   (io_done),
    .rdata_o  (io_rdata)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= GS_IDLE;
      op_q       <= GS_OP_WR_DATA;
      data_q     <= 8'h00;
      xfer_q     <= 1'b0;
      gap_q      <= 4'd0;
      stat_q     <= 8'h00;
      rsp_data_q <= 8'h00;
`ifdef GS_HOST_TIMEOUT_EN
      rsp_to_q   <= 1'b0;
      fail_q     <= 16'd0;
`endif
    end else begin
      state_q    <= state_d;
      xfer_q     <= xfer_d;
      gap_q      <= gap_d;
      stat_q     <= stat_d;
      rsp_data_q <= rsp_data_d;
`ifdef GS_HOST_TIMEOUT_EN
      rsp_to_q   <= rsp_to_d;
      fail_q     <= fail_d;
`endif
      if (accept) begin
        op_q   <= gs_op_e'(REQ_OP);
        data_q <= REQ_DATA;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    xfer_d     = xfer_q;
    gap_d      = gap_q;
    stat_d     = stat_q;
    rsp_data_d = rsp_data_q;
    io_start   = 1'b0;
    accept     = 1'b0;
`ifdef GS_HOST_TIMEOUT_EN
    rsp_to_d   = rsp_to_q;
    fail_d     = fail_q;
    fail_inc   = fail_q + 16'd1;
`endif
    unique case (op_q)
      GS_OP_WR_DATA: poll_ok = !io_rdata[GS_FLAG_DATA];
      GS_OP_WR_CMD:  poll_ok = !io_rdata[GS_FLAG_CMD];
      GS_OP_RD_DATA: poll_ok = io_rdata[GS_FLAG_DATA];
      default:       poll_ok = 1'b1;
    endcase

    unique case (state_q)
      GS_IDLE: begin
        if (REQ_VALID) begin
          accept   = 1'b1;
          io_start = 1'b1;
          state_d  = GS_EVAL;
          xfer_d   = (gs_op_e'(REQ_OP) == GS_OP_RD_STAT);
`ifdef GS_HOST_TIMEOUT_EN
          fail_d   = 16'd0;
`endif
        end
      end
      // EVAL spans the in-flight cycle; its result is judged on the RELEASE clock
      GS_EVAL: begin
        if (io_done) begin
          if (xfer_q) begin
            rsp_data_d = op_q[1] ? io_rdata : stat_q;
            state_d    = GS_DONE;
`ifdef GS_HOST_TIMEOUT_EN
            rsp_to_d   = 1'b0;
`endif
          end else begin
            stat_d = io_rdata;
            if (poll_ok) xfer_d = 1'b1;
`ifdef GS_HOST_TIMEOUT_EN
            else if (fail_inc == 16'(TIMEOUT)) begin
              rsp_data_d = io_rdata;
              rsp_to_d   = 1'b1;
              state_d    = GS_DONE;
            end else begin
              fail_d = fail_inc;
            end
`endif
            if (state_d != GS_DONE) begin
              if (GAP == 0) begin
                io_start = 1'b1;
              end else begin
                state_d = GS_GAP;
                gap_d   = GAP_M1;
              end
            end
          end
        end
      end
      GS_GAP: begin
        if (gap_q == 4'd0) begin
          io_start = 1'b1;
          state_d  = GS_EVAL;
        end else begin
          gap_d = gap_q - 4'd1;
        end
      end
      GS_DONE: state_d = GS_IDLE;
      default: state_d = GS_IDLE;
    endcase

    cur_op   = (state_q == GS_IDLE) ? gs_op_e'(REQ_OP) : op_q;
    io_wdata = (state_q == GS_IDLE) ? REQ_DATA : data_q;
    if (!xfer_d) begin
      io_addr = GS_PORT_CMD;
      io_rd   = 1'b1;
    end else begin
      unique case (cur_op)
        GS_OP_WR_DATA: begin io_addr = GS_PORT_DATA; io_rd = 1'b0; end
        GS_OP_WR_CMD:  begin io_addr = GS_PORT_CMD;  io_rd = 1'b0; end
        GS_OP_RD_DATA: begin io_addr = GS_PORT_DATA; io_rd = 1'b1; end
        default:       begin io_addr = GS_PORT_CMD;  io_rd = 1'b1; end
      endcase
    end
  end

  always_comb begin
    REQ_READY = (state_q == GS_IDLE);
    BUSY      = (state_q != GS_IDLE);
    RSP_VALID = (state_q == GS_DONE);
    RSP_DATA  = rsp_data_q;
    M1_n      = 1'b1;
`ifdef GS_HOST_TIMEOUT_EN
    RSP_TIMEOUT = rsp_to_q;
`else
    RSP_TIMEOUT = 1'b0;
`endif
  end

endmodule

// File: tb/tb_gs_host_master.sv
// Directed bench for gs_host_master with a small behavioural GS status/data model on the host bus.
module tb_gs_host_master;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        REQ_VALID = 1'b0;
  logic        REQ_READY;
  logic [1:0]  REQ_OP = 2'b00;
  logic [7:0]  REQ_DATA = 8'h00;
  logic        RSP_VALID;
  logic [7:0]  RSP_DATA;
  logic        RSP_TIMEOUT;
  logic        BUSY;
  logic [15:0] A;
  logic [7:0]  DO;
  logic [7:0]  DI;
  logic        IORQ_n, RD_n, WR_n, M1_n;

  int n_checks = 0;
  int n_fail = 0;

  gs_host_master #(.STROBE(4), .GAP(2), .TIMEOUT(4)) dut (
    .CLK(CLK), .RESET(RESET), .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
    .REQ_OP(REQ_OP), .REQ_DATA(REQ_DATA), .RSP_VALID(RSP_VALID), .RSP_DATA(RSP_DATA),
    .RSP_TIMEOUT(RSP_TIMEOUT), .BUSY(BUSY), .A(A), .DO(DO), .DI(DI),
    .IORQ_n(IORQ_n), .RD_n(RD_n), .WR_n(WR_n), .M1_n(M1_n)
  );

  always #5 CLK = ~CLK;

  // GS side model: flags, GS->host data byte, cycle counters
  logic       d_flag = 1'b0, c_flag = 1'b0;
  logic [7:0] gs_data = 8'h00;
  int         cmd_busy = 0;
  int         n_rd_bb = 0, n_rd_b3 = 0, n_wr_b3 = 0, n_wr_bb = 0, n_both = 0;
  logic [7:0] do_seen = 8'h00, wr_byte = 8'h00;
  logic       prev_rd_n = 1'b1, prev_wr_n = 1'b1;

  logic       load_req = 1'b0, load_d = 1'b0, load_c = 1'b0;
  int         load_busy = 0;
  logic [7:0] load_data = 8'h00;

  assign DI = (A == 16'h00BB) ? {d_flag, 6'b111111, c_flag} : gs_data;

  always @(posedge CLK) begin
    if (load_req) begin
      d_flag   = load_d;
      c_flag   = load_c;
      cmd_busy = load_busy;
      gs_data  = load_data;
    end
    if (!RD_n && !WR_n) n_both++;
    if (!WR_n) do_seen = DO;
    if (!prev_rd_n && RD_n) begin
      if (A == 16'h00BB) begin
        n_rd_bb++;
        if (cmd_busy > 0) begin
          cmd_busy--;
          if (cmd_busy == 0) c_flag = 1'b0;
        end
      end else if (A == 16'h00B3) begin
        n_rd_b3++;
        d_flag = 1'b0;
      end
    end
    if (!prev_wr_n && WR_n) begin
      if (A == 16'h00B3) begin
        n_wr_b3++; d_flag = 1'b1; wr_byte = do_seen;
      end else if (A == 16'h00BB) begin
        n_wr_bb++; c_flag = 1'b1; wr_byte = do_seen;
      end
    end
    prev_rd_n = RD_n;
    prev_wr_n = WR_n;
  end

  task automatic load_gs(input logic d, input logic c, input int busy, input logic [7:0] data);
    @(negedge CLK);
    load_req = 1'b1; load_d = d; load_c = c; load_busy = busy; load_data = data;
    @(posedge CLK);
    #1 load_req = 1'b0;
  endtask

  // drives one request; cyc = clock index of RSP_VALID relative to the accept edge (-1 if none)
  task automatic issue(input logic [1:0] op, input logic [7:0] d, output int cyc, output bit setup_ok);
    @(negedge CLK);
    REQ_VALID = 1'b1; REQ_OP = op; REQ_DATA = d;
    @(posedge CLK);
    #1 REQ_VALID = 1'b0; REQ_DATA = 8'hEE;
    @(negedge CLK);
    cyc = 1;
    setup_ok = (IORQ_n === 1'b0) && (RD_n === 1'b1) && (WR_n === 1'b1) && (A === 16'h00BB);
    while (RSP_VALID !== 1'b1 && cyc < 2000) begin
      @(negedge CLK);
      cyc++;
    end
    if (cyc >= 2000) cyc = -1;
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    n_checks++;
    if ({REQ_READY, BUSY, RSP_VALID, RSP_TIMEOUT, IORQ_n, RD_n, WR_n, M1_n} !== 8'b1000_1111) begin
      $display("FAIL reset_ctrl: got %b expected 10001111", {REQ_READY, BUSY, RSP_VALID, RSP_TIMEOUT, IORQ_n, RD_n, WR_n, M1_n});
      n_fail++;
    end
    n_checks++;
    if ({A, DO, RSP_DATA} !== 32'h0) begin
      $display("FAIL reset_bus: got A=%h DO=%h RSP=%h expected zeros", A, DO, RSP_DATA);
      n_fail++;
    end
    RESET = 1'b0;
  endtask

  task automatic test_wr_data();
    int cyc; bit su; int rb, wb;
    load_gs(1'b0, 1'b0, 0, 8'h00);
    rb = n_rd_bb; wb = n_wr_b3;
    issue(2'b00, 8'h5A, cyc, su);
    n_checks++;
    if (cyc != 15 || !su) begin $display("FAIL wr_data_timing: got cyc=%0d setup=%0d expected 15/1", cyc, su); n_fail++; end
    n_checks++;
    if (n_rd_bb - rb != 1 || n_wr_b3 - wb != 1) begin
      $display("FAIL wr_data_cycles: got polls=%0d writes=%0d expected 1/1", n_rd_bb - rb, n_wr_b3 - wb); n_fail++;
    end
    n_checks++;
    if (wr_byte !== 8'h5A || d_flag !== 1'b1) begin
      $display("FAIL wr_data_byte: got byte=%h flag=%b expected 5a/1", wr_byte, d_flag); n_fail++;
    end
    n_checks++;
    if (RSP_DATA !== 8'h7E || RSP_TIMEOUT !== 1'b0) begin
      $display("FAIL wr_data_rsp: got %h/%b expected 7e/0", RSP_DATA, RSP_TIMEOUT); n_fail++;
    end
  endtask

  task automatic test_wr_cmd_poll();
    int cyc; bit su; int rb, wb;
    load_gs(1'b1, 1'b1, 3, 8'h00);
    rb = n_rd_bb; wb = n_wr_bb;
    issue(2'b01, 8'h23, cyc, su);
    n_checks++;
    if (cyc != 39) begin $display("FAIL wr_cmd_timing: got cyc=%0d expected 39", cyc); n_fail++; end
    n_checks++;
    if (n_rd_bb - rb != 4 || n_wr_bb - wb != 1 || wr_byte !== 8'h23) begin
      $display("FAIL wr_cmd_cycles: got polls=%0d writes=%0d byte=%h expected 4/1/23", n_rd_bb - rb, n_wr_bb - wb, wr_byte); n_fail++;
    end
    n_checks++;
    if (RSP_DATA !== 8'hFE) begin $display("FAIL wr_cmd_rsp: got %h expected fe", RSP_DATA); n_fail++; end
  endtask

  task automatic test_rd_data();
    int cyc; bit su; int rd;
    load_gs(1'b1, 1'b0, 0, 8'hC4);
    rd = n_rd_b3;
    issue(2'b10, 8'h00, cyc, su);
    n_checks++;
    if (cyc != 15) begin $display("FAIL rd_data_timing: got cyc=%0d expected 15", cyc); n_fail++; end
    n_checks++;
    if (RSP_DATA !== 8'hC4 || d_flag !== 1'b0 || n_rd_b3 - rd != 1) begin
      $display("FAIL rd_data_rsp: got %h flag=%b reads=%0d expected c4/0/1", RSP_DATA, d_flag, n_rd_b3 - rd); n_fail++;
    end
  endtask

  task automatic test_rd_stat();
    int cyc; bit su; int rb;
    load_gs(1'b1, 1'b0, 0, 8'h00);
    rb = n_rd_bb;
    issue(2'b11, 8'h00, cyc, su);
    n_checks++;
    if (cyc != 7 || !su || n_rd_bb - rb != 1) begin
      $display("FAIL rd_stat_timing: got cyc=%0d setup=%0d reads=%0d expected 7/1/1", cyc, su, n_rd_bb - rb); n_fail++;
    end
    n_checks++;
    if (RSP_DATA !== 8'hFE) begin $display("FAIL rd_stat_rsp: got %h expected fe", RSP_DATA); n_fail++; end
    repeat (3) @(negedge CLK);
    n_checks++;
    if (RSP_DATA !== 8'hFE || RSP_VALID !== 1'b0 || REQ_READY !== 1'b1) begin
      $display("FAIL rsp_hold: got %h valid=%b ready=%b expected fe/0/1", RSP_DATA, RSP_VALID, REQ_READY); n_fail++;
    end
  endtask

  task automatic test_back_to_back();
    int c1, c2; bit s1, s2;
    load_gs(1'b0, 1'b1, 0, 8'h00);
    issue(2'b11, 8'h00, c1, s1);
    issue(2'b11, 8'h00, c2, s2);
    n_checks++;
    if (c1 != 7 || c2 != 7 || !s1 || !s2 || RSP_DATA !== 8'h7F) begin
      $display("FAIL back_to_back: got cyc=%0d,%0d setup=%0d,%0d rsp=%h expected 7,7 1,1 7f", c1, c2, s1, s2, RSP_DATA); n_fail++;
    end
  endtask

  task automatic test_busy_ignore();
    int cyc, rsps, wb, rb;
    load_gs(1'b0, 1'b0, 0, 8'h00);
    wb = n_wr_b3; rb = n_rd_bb; rsps = 0;
    @(negedge CLK);
    REQ_VALID = 1'b1; REQ_OP = 2'b11;
    @(posedge CLK);
    #1 REQ_OP = 2'b00; REQ_DATA = 8'h99;
    for (int i = 1; i <= 30; i++) begin
      @(negedge CLK);
      if (i == 5) REQ_VALID = 1'b0;
      if (RSP_VALID === 1'b1) begin rsps++; cyc = i; end
    end
    n_checks++;
    if (rsps != 1 || cyc != 7 || n_wr_b3 != wb || n_rd_bb - rb != 1 || RSP_DATA !== 8'h7E) begin
      $display("FAIL busy_ignore: got rsps=%0d cyc=%0d writes=%0d reads=%0d rsp=%h expected 1/7/0/1/7e",
               rsps, cyc, n_wr_b3 - wb, n_rd_bb - rb, RSP_DATA); n_fail++;
    end
  endtask

  task automatic test_reset_mid_write();
    int wb, rsps, n;
    load_gs(1'b0, 1'b0, 0, 8'h00);
    wb = n_wr_bb; rsps = 0; n = 0;
    @(negedge CLK);
    REQ_VALID = 1'b1; REQ_OP = 2'b01; REQ_DATA = 8'h42;
    @(posedge CLK);
    #1 REQ_VALID = 1'b0;
    @(negedge CLK);
    while (WR_n !== 1'b0 && n < 100) begin @(negedge CLK); n++; end
    n_checks++;
    if (n >= 100) begin $display("FAIL mid_reset_strobe: got no WR_n low, expected one"); n_fail++; end
    RESET = 1'b1;
    @(posedge CLK);
    #1;
    n_checks++;
    if ({WR_n, IORQ_n, RD_n, REQ_READY, BUSY, RSP_VALID} !== 6'b111100) begin
      $display("FAIL mid_reset_bus: got %b expected 111100", {WR_n, IORQ_n, RD_n, REQ_READY, BUSY, RSP_VALID}); n_fail++;
    end
    @(negedge CLK);
    RESET = 1'b0;
    repeat (30) begin
      @(negedge CLK);
      if (RSP_VALID === 1'b1) rsps++;
    end
    n_checks++;
    if (rsps != 0 || n_wr_bb != wb || REQ_READY !== 1'b1 || RSP_DATA !== 8'h00) begin
      $display("FAIL mid_reset_drop: got rsps=%0d writes=%0d ready=%b rsp=%h expected 0/0/1/00",
               rsps, n_wr_bb - wb, REQ_READY, RSP_DATA); n_fail++;
    end
  endtask

`ifdef GS_HOST_TIMEOUT_EN
  task automatic test_timeout();
    int cyc; bit su; int rb, wb;
    load_gs(1'b1, 1'b1, 0, 8'h00);
    rb = n_rd_bb; wb = n_wr_b3;
    issue(2'b00, 8'h11, cyc, su);
    n_checks++;
    if (cyc != 31 || n_rd_bb - rb != 4 || n_wr_b3 != wb) begin
      $display("FAIL timeout_cycles: got cyc=%0d polls=%0d writes=%0d expected 31/4/0", cyc, n_rd_bb - rb, n_wr_b3 - wb); n_fail++;
    end
    n_checks++;
    if (RSP_TIMEOUT !== 1'b1 || RSP_DATA !== 8'hFF) begin
      $display("FAIL timeout_rsp: got %b/%h expected 1/ff", RSP_TIMEOUT, RSP_DATA); n_fail++;
    end
  endtask
`endif

  initial begin
    test_reset();
    test_wr_data();
    test_wr_cmd_poll();
    test_rd_data();
    test_rd_stat();
    test_back_to_back();
    test_busy_ignore();
`ifdef GS_HOST_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid_write();
    n_checks++;
    if (n_both != 0) begin $display("FAIL rd_wr_overlap: got %0d clocks expected 0", n_both); n_fail++; end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gs_host_master.md
# gs_host_master

Host-side initiator for the General Sound mailbox: turns byte-level requests (write data, write command, read data, read status) into correctly timed I/O cycles on ports #B3/#BB. It follows the GS flag handshake by polling status port #BB before each transfer. It sits between a loader/MCU request source and the host-side bus of the GS core, replacing the Z80 host for uploading sample/module data and issuing GS commands.

## Interface
Parameters:
- STROBE, 4: clocks RD_n/WR_n held low per I/O cycle (1..15).
- GAP, 2: idle clocks between consecutive I/O cycles (0..15).
- TIMEOUT, 65535: failed polls before a request is aborted (1..65535).

Ports:
- Clocking: one clock; reset is synchronous and active-high.
- CLK  in  1  system clock.
- RESET  in  1  synchronous, active-high reset.
- REQ_VALID  in  1  request present.
- REQ_READY  out  1  block idle; request accepted on the edge where VALID & READY.
- REQ_OP  in  2  00 write data #B3, 01 write command #BB, 10 read data #B3, 11 read status #BB.
- REQ_DATA  in  8  byte for write ops; ignored for reads.
- RSP_VALID  out  1  one-clock completion pulse.
- RSP_DATA  out  8  read byte (ops 10/11); for writes, last status read.
- RSP_TIMEOUT  out  1  qualifies RSP_VALID: request aborted.
- BUSY  out  1  request in progress (inverse of REQ_READY).
- A  out  16  I/O address: 16'h00B3 or 16'h00BB during cycles, 16'h0000 idle.
- DO  out  8  write data toward GS.
- DI  in  8  GS read data, valid while RD_n low.
- IORQ_n, RD_n, WR_n, M1_n  out  1 each  host bus strobes; M1_n constant 1.

## Operation
- States: IDLE, SETUP, STROBE, RELEASE, EVAL, GAP, DONE.
- Status byte: bit7 = data flag, bit0 = command flag.
- Poll condition per op:
  - op 00: proceed when bit7 = 0.
  - op 01: proceed when bit0 = 0.
  - op 10: proceed when bit7 = 1.
  - op 11: no poll; a single #BB read whose byte is the response.
- I/O cycle (poll or transfer):
  - SETUP, 1 clock: A valid, IORQ_n = 0, RD_n = WR_n = 1.
  - STROBE, STROBE clocks: RD_n = 0 or WR_n = 0.
  - RELEASE, 1 clock: strobes and IORQ_n high, A held.
- DI is sampled on the last STROBE clock of a read cycle. DO = REQ_DATA (latched at accept) from SETUP through RELEASE.
- Poll failure: GAP clocks, re-poll, fail counter +1. Poll success: GAP clocks, then the transfer cycle.
- DONE, 1 clock: RSP_VALID = 1, then IDLE. RSP_DATA/RSP_TIMEOUT hold until the next DONE.
- Never issues RD_n and WR_n together. At most one I/O cycle is in flight.
- Reset values: REQ_READY = 1, BUSY = 0, RSP_VALID = 0, RSP_DATA = 8'h00, RSP_TIMEOUT = 0, A = 0, DO = 0, IORQ_n = RD_n = WR_n = M1_n = 1, fail counter = 0.
- RESET mid-request: all strobes high on the next edge and the request is dropped with no RSP_VALID.
- REQ_VALID while BUSY is ignored (no queuing). REQ_* is latched only at accept.

## Timing
- Acceptance edge = cycle 0. SETUP of the first cycle is on cycle 1.
- Cycle length = STROBE + 2 clocks.
- Flag ready on first poll: RSP_VALID at cycle 2·(STROBE+2) + GAP + 1. This is 15 with defaults.
- Each failed poll adds STROBE + 2 + GAP clocks.
- Op 11: RSP_VALID at cycle STROBE + 3.
- REQ_READY returns on the clock after DONE.
- Back-to-back requests: the first SETUP follows the accept with no gap.

## Configuration
- GS_HOST_TIMEOUT_EN defined:
  - A 16-bit fail counter compares against TIMEOUT.
  - When it is reached, the block goes to DONE with RSP_TIMEOUT = 1 and RSP_DATA = last status; no transfer cycle is issued.
- Undefined:
  - No counter is built; polling continues indefinitely.
  - RSP_TIMEOUT is tied to 0.
  - The TIMEOUT parameter is unused.

## Structure
- Package gs_pkg holds:
  - op encodings: GS_OP_WR_DATA, GS_OP_WR_CMD, GS_OP_RD_DATA, GS_OP_RD_STAT;
  - port constants GS_PORT_DATA = 8'hB3 and GS_PORT_CMD = 8'hBB;
  - flag bit indices GS_FLAG_DATA = 7 and GS_FLAG_CMD = 0;
  - the state enum.
- One sub-module, gs_io_cycle, generates a single SETUP/STROBE/RELEASE cycle (start, addr, rd/wr, done, captured data).
- The top level holds the poll/gap/response FSM and the counter.

## Test plan
- Op 00, data 8'h5A, GS data flag 0: one #BB read, then #B3 write of 5A. RSP_VALID at cycle 15; GS-side bit7 = 1 afterwards.
- Op 01, data 8'h23, command flag held 1 for 3 polls then cleared by GS Z80: four #BB reads, then #BB write of 23. RSP_VALID at cycle 15 + 3·8 = 39.
- Op 10 with the GS Z80 having written 8'hC4 to its port 3: poll sees bit7 = 1. RSP_DATA = C4, GS bit7 cleared.
- Op 11: single #BB read. RSP_DATA = {bit7, 6'b111111, bit0}, RSP_VALID at cycle 7.
- With GS_HOST_TIMEOUT_EN and TIMEOUT = 4, op 00 with bit7 stuck at 1: exactly 4 polls, no #B3 write, RSP_TIMEOUT = 1.
- RESET asserted during the STROBE of a write: WR_n = 1 and IORQ_n = 1 on the next edge, no RSP_VALID, REQ_READY = 1.
